// File: rtl/spm_wb_ctrl_if.sv
// Wishbone slave bundle between the management-core bus and spm_wb_ctrl.
// Signal names keep the Caravel wbs_* naming so the top level wires up one-to-one.
interface spm_wb_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/spm_wb_ctrl.sv
// Wishbone job controller for the 32x32 serial-parallel multiplier: loads operands,
// pulses start, waits for a fresh done edge or timeout, and collects both product halves.
module spm_wb_ctrl #(
    parameter logic [31:0] ADDR_BASE      = 32'h3000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    spm_wb_ctrl_if.slave        wb,
    output logic [31:0]         spm_mc,
    output logic [31:0]         spm_mp,
    output logic                spm_start,
    output logic                spm_prod_sel,
    input  logic                spm_done,
    input  logic [31:0]         spm_prod,
    output logic                irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_SEL_LO,
        S_SEL_HI
    } state_t;

    localparam logic [2:0]  REG_MC     = 3'd0;
    localparam logic [2:0]  REG_MP     = 3'd1;
    localparam logic [2:0]  REG_CTRL   = 3'd2;
    localparam logic [2:0]  REG_PROD_L = 3'd3;
    localparam logic [2:0]  REG_PROD_H = 3'd4;
    localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        done_q;
    logic        done_edge;
    logic        start_nxt, sel_nxt;

    logic [31:0] mc, mp, prod_lo, prod_hi;
    logic        flag_done, flag_to, flag_err, irq_en;

    logic        hit, req;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        req_we;
    logic [2:0]  req_idx;
    logic [31:0] req_dat;
    logic [31:0] rd_data;

    logic        busy;
    logic        wr_mc, wr_mp, wr_ctrl;
    logic        go, clr, err_set, done_set, to_set;
    logic        unused_bits;

    assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0]};

    // ---------------- Wishbone front end ----------------
    assign hit = (wb.wbs_adr_i[31:5] == ADDR_BASE[31:5]);
    assign req = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q & hit;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rd_data = '0;
        case (wb.wbs_adr_i[4:2])
            REG_MC:     rd_data = mc;
            REG_MP:     rd_data = mp;
            REG_CTRL:   rd_data = {27'd0, irq_en, flag_err, flag_to, flag_done, busy};
            REG_PROD_L: rd_data = prod_lo;
            REG_PROD_H: rd_data = prod_hi;
            default:    rd_data = '0;
        endcase
    end

    // The request is latched so the write lands in the ack cycle regardless of when
    // the master drops its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            req_we  <= 1'b0;
            req_idx <= '0;
            req_dat <= '0;
        end else begin
            ack_q <= req;
            dat_q <= (req && !wb.wbs_we_i) ? rd_data : '0;
            if (req) begin
                req_we  <= wb.wbs_we_i;
                req_idx <= wb.wbs_adr_i[4:2];
                req_dat <= wb.wbs_dat_i;
            end
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;

    // ---------------- register writes and flags ----------------
    assign busy     = (state != S_IDLE);
    assign wr_mc    = ack_q & req_we & (req_idx == REG_MC);
    assign wr_mp    = ack_q & req_we & (req_idx == REG_MP);
    assign wr_ctrl  = ack_q & req_we & (req_idx == REG_CTRL);
    assign go       = wr_ctrl & req_dat[0] & ~busy;
    assign clr      = wr_ctrl & req_dat[1];
    assign err_set  = busy & (wr_mc | wr_mp | (wr_ctrl & req_dat[0]));
    assign done_set = (state == S_SEL_HI);
    assign to_set   = (state == S_BUSY) & ~done_edge & (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc        <= '0;
            mp        <= '0;
            prod_lo   <= '0;
            prod_hi   <= '0;
            flag_done <= 1'b0;
            flag_to   <= 1'b0;
            flag_err  <= 1'b0;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_mc && !busy) mc <= req_dat;
            if (wr_mp && !busy) mp <= req_dat;
            if (wr_ctrl)        irq_en <= req_dat[2];
            if (state == S_SEL_LO) prod_lo <= spm_prod;
            if (state == S_SEL_HI) prod_hi <= spm_prod;
            // A set in the same cycle as CLR wins.
            flag_done <= done_set | (flag_done & ~clr);
            flag_to   <= to_set   | (flag_to   & ~clr);
            flag_err  <= err_set  | (flag_err  & ~clr);
            irq       <= irq_en & (flag_done | flag_to);
        end
    end

    assign spm_mc = mc;
    assign spm_mp = mp;

    // ---------------- sequencer ----------------
    assign done_edge = spm_done & ~done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            done_q       <= 1'b0;
            spm_start    <= 1'b0;
            spm_prod_sel <= 1'b0;
        end else begin
            state        <= state_nxt;
            done_q       <= spm_done;
            spm_start    <= start_nxt;
            spm_prod_sel <= sel_nxt;
            if (state == S_START)     cnt <= '0;
            else if (state == S_BUSY) cnt <= cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (go) state_nxt = S_START;
            S_START:  state_nxt = S_BUSY;
            S_BUSY: begin
                if (done_edge)            state_nxt = S_SEL_LO;
                else if (cnt == CNT_LAST) state_nxt = S_IDLE;
            end
            S_SEL_LO: state_nxt = S_SEL_HI;
            S_SEL_HI: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state.
    always_comb begin
        start_nxt = (state_nxt == S_START);
        sel_nxt   = (state_nxt == S_SEL_HI);
    end

endmodule
